cube_scan_driver: RTL and testbench

CUBE_SCAN_DRIVER -- requirements
Module: cube_scan_driver

---
 rtl/cube_scan_driver.sv | 172 +++++++++++++++++
 tb/tb_cube_scan_driver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cube_scan_driver.sv
// Multiplexed LED-cube scan driver with a double-buffered frame store.
// A producer hands a full frame to the shadow buffer through a
// FrameValid/FrameReady handshake. The shadow is copied into the display
// buffer at the next frame boundary. Layers are scanned one at a time. Each
// layer starts with a blanking interval for anti-ghosting, and a PWM duty
// cycle then sets its brightness.
//
// Ports:
//   Clk        - clock, rising edge
//   Reset      - asynchronous, active-high reset
//   Cells      - frame input, bit = layer*N*N + row*N + col
//   FrameValid - producer offers Cells
//   FrameReady - shadow buffer free (registered, = !pending)
//   Brightness - PWM duty level, sampled at the start of each layer
//   Enable     - scan enable; low forces outputs and counters to 0
//   LayerSel   - one-hot layer drive, active high
//   ColData    - column drives for the current layer, bit = row*N + col
//   FrameStart - one-cycle pulse at each frame start
module cube_scan_driver #(
  parameter int unsigned N        = 8,
  parameter int unsigned DWELL    = 1024,
  parameter int unsigned BLANK    = 16,
  parameter int unsigned BRIGHT_W = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N*N*N-1:0]    Cells,
  input  logic                FrameValid,
  output logic                FrameReady,
  input  logic [BRIGHT_W-1:0] Brightness,
  input  logic                Enable,
  output logic [N-1:0]        LayerSel,
  output logic [N*N-1:0]      ColData,
  output logic                FrameStart
);

  localparam int unsigned CELLS   = N * N * N;
  localparam int unsigned PLANE   = N * N;
  localparam int unsigned LAYER_W = $clog2(N);
  localparam int unsigned DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [DWELL_W-1:0] BLANK_V    = DWELL_W'(BLANK);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(N - 1);

  logic [CELLS-1:0]    shadow_q,      shadow_d;
  logic [CELLS-1:0]    display_q,     display_d;
  logic                pending_q,     pending_d;
  logic [DWELL_W-1:0]  dwell_q,       dwell_d;
  logic [LAYER_W-1:0]  layer_q,       layer_d;
  logic [BRIGHT_W-1:0] pwm_q,         pwm_d;
  logic [BRIGHT_W-1:0] bright_q,      bright_d;
  logic [N-1:0]        layer_sel_q,   layer_sel_d;
  logic [PLANE-1:0]    col_data_q,    col_data_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_ready_q, frame_ready_d;

  logic                boundary;
  logic                capture;
  logic                swap;
  logic                post_blank;
  logic                lit;
  logic [BRIGHT_W-1:0] bright_eff;
  logic [N-1:0]        layer_onehot;
  logic [PLANE-1:0]    plane;

  // Next-state and registered-output logic.
  always_comb begin
    shadow_d      = shadow_q;
    display_d     = display_q;
    pending_d     = pending_q;
    dwell_d       = dwell_q;
    layer_d       = layer_q;
    pwm_d         = pwm_q;
    bright_d      = bright_q;
    layer_sel_d   = '0;
    col_data_d    = '0;
    frame_start_d = 1'b0;
    frame_ready_d = frame_ready_q;
    layer_onehot  = '0;
    plane         = '0;

    // A disabled cycle counts as a frame boundary, so a pending frame swaps
    // in right away. Capture needs pending=0 and swap needs pending=1, so
    // the two never happen on the same edge.
    boundary = !Enable || (layer_q == LAYER_LAST && dwell_q == DWELL_LAST);
    capture  = FrameValid && frame_ready_q;
    swap     = pending_q && boundary;

    if (swap) begin
      display_d = shadow_q;
      pending_d = 1'b0;
    end else if (capture) begin
      shadow_d  = Cells;
      pending_d = 1'b1;
    end
    frame_ready_d = !pending_d;

    // Brightness is latched at dwell 0. The live value is used on that one
    // cycle so the latch is never a layer stale.
    bright_eff = (dwell_q == '0) ? Brightness : bright_q;
    if (dwell_q == '0) begin
      bright_d = Brightness;
    end

    post_blank = (dwell_q >= BLANK_V);
    lit = Enable && post_blank &&
          ((pwm_q < bright_eff) || (bright_eff == '1));

    for (int unsigned l = 0; l < N; l++) begin
      if (layer_q == LAYER_W'(l)) begin
        layer_onehot[l] = 1'b1;
        plane           = display_q[l*PLANE +: PLANE];
      end
    end

    if (lit) begin
      layer_sel_d = layer_onehot;
      col_data_d  = plane;
    end
    frame_start_d = Enable && (layer_q == '0) && (dwell_q == '0);

    // Scan counters; PWM restarts at the first post-blank cycle of each layer.
    if (!Enable) begin
      dwell_d = '0;
      layer_d = '0;
      pwm_d   = '0;
    end else if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      pwm_d   = '0;
      layer_d = (layer_q == LAYER_LAST) ? '0 : layer_q + LAYER_W'(1);
    end else begin
      dwell_d = dwell_q + DWELL_W'(1);
      pwm_d   = post_blank ? pwm_q + BRIGHT_W'(1) : '0;
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shadow_q      <= '0;
      display_q     <= '0;
      pending_q     <= 1'b0;
      dwell_q       <= '0;
      layer_q       <= '0;
      pwm_q         <= '0;
      bright_q      <= '0;
      layer_sel_q   <= '0;
      col_data_q    <= '0;
      frame_start_q <= 1'b0;
      frame_ready_q <= 1'b1;
    end else begin
      shadow_q      <= shadow_d;
      display_q     <= display_d;
      pending_q     <= pending_d;
      dwell_q       <= dwell_d;
      layer_q       <= layer_d;
      pwm_q         <= pwm_d;
      bright_q      <= bright_d;
      layer_sel_q   <= layer_sel_d;
      col_data_q    <= col_data_d;
      frame_start_q <= frame_start_d;
      frame_ready_q <= frame_ready_d;
    end
  end

  assign FrameReady = frame_ready_q;
  assign LayerSel   = layer_sel_q;
  assign ColData    = col_data_q;
  assign FrameStart = frame_start_q;

endmodule

// File: tb/tb_cube_scan_driver.sv
// Testbench for cube_scan_driver (N=4, DWELL=32, BLANK=4, BRIGHT_W=2).
// The driver computes the expected outputs with a frame-level reference
// model and queues them. A monitor pops one entry per clock and compares
// it with the DUT outputs.
module tb_cube_scan_driver;

  localparam int unsigned N     = 4;
  localparam int unsigned DWELL = 32;
  localparam int unsigned BLANK = 4;
  localparam int unsigned BW    = 2;
  localparam int unsigned PLANE = N * N;
  localparam int unsigned FRAME = N * DWELL;

  logic              Clk;
  logic              Reset;
  logic [N*N*N-1:0]  Cells;
  logic              FrameValid;
  logic              FrameReady;
  logic [BW-1:0]     Brightness;
  logic              Enable;
  logic [N-1:0]      LayerSel;
  logic [PLANE-1:0]  ColData;
  logic              FrameStart;

  cube_scan_driver #(.N(N), .DWELL(DWELL), .BLANK(BLANK), .BRIGHT_W(BW)) dut (
    .Clk(Clk), .Reset(Reset), .Cells(Cells), .FrameValid(FrameValid),
    .FrameReady(FrameReady), .Brightness(Brightness), .Enable(Enable),
    .LayerSel(LayerSel), .ColData(ColData), .FrameStart(FrameStart)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [N-1:0]     ls;
    logic [PLANE-1:0] col;
    logic             fs;
    logic             fr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lit_cnt  = 0;
  bit   en_broken = 1'b1;

  // Reference model state: a global scan position t within the frame.
  logic [63:0] m_shadow = '0;
  logic [63:0] m_disp   = '0;
  bit          m_pending = 1'b0;
  int          m_t = 0;
  int          m_bsamp = 0;

  // Stimulus for the next cycle.
  bit          in_rst = 1'b1;
  bit          in_en  = 1'b0;
  bit          in_fv  = 1'b0;
  logic [63:0] in_cells = '0;
  int          in_bright = 0;
  bit          prev_rst = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model, queue the expected outputs, drive inputs.
  task automatic cycle();
    exp_t e;
    int   layer, dwell, b;
    bit   lit, boundary;
    if (in_rst) begin
      m_shadow = '0; m_disp = '0; m_pending = 1'b0; m_t = 0; m_bsamp = 0;
      e.ls = '0; e.col = '0; e.fs = 1'b0; e.fr = 1'b1;
      en_broken = 1'b1;
    end else begin
      layer = (m_t / DWELL) % N;
      dwell = m_t % DWELL;
      if (dwell == 0) m_bsamp = in_bright;
      b   = m_bsamp;
      lit = in_en && (dwell >= BLANK) &&
            ((((dwell - BLANK) % (1 << BW)) < b) || (b == (1 << BW) - 1));
      e.ls  = lit ? N'(1 << layer) : '0;
      e.col = lit ? m_disp[layer*PLANE +: PLANE] : '0;
      e.fs  = in_en && (m_t == 0);
      boundary = !in_en || (m_t == FRAME - 1);
      if (m_pending && boundary) begin
        m_disp = m_shadow; m_pending = 1'b0;
      end else if (in_fv && !m_pending) begin
        m_shadow = in_cells; m_pending = 1'b1;
      end
      e.fr = !m_pending;
      m_t = in_en ? (m_t + 1) % FRAME : 0;
      if (!in_en) en_broken = 1'b1;
    end
    exp_q.push_back(e);
    Reset      = in_rst;
    Enable     = in_en;
    FrameValid = in_fv;
    Cells      = in_cells;
    Brightness = BW'(in_bright);
    if (in_rst && !prev_rst) begin
      // Reset asserted between edges must clear the outputs immediately.
      #1;
      check("rst_async_ls",  64'(LayerSel),   64'd0);
      check("rst_async_col", 64'(ColData),    64'd0);
      check("rst_async_fs",  64'(FrameStart), 64'd0);
      check("rst_async_fr",  64'(FrameReady), 64'd1);
    end
    prev_rst = in_rst;
    @(negedge Clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 2 * FRAME && m_t != target; i++) cycle();
    check("run_to_pos", 64'(m_t), 64'(target));
  endtask

  task automatic lit_window(input int bright, input int want);
    in_bright = bright;
    run(FRAME);
    lit_cnt = 0;
    run(FRAME);
    check($sformatf("lit_cycles_b%0d", bright), 64'(lit_cnt), 64'(want));
  endtask

  // Monitor: one queued expectation per clock, plus invariants.
  initial begin
    exp_t e;
    int   cyc = 0;
    int   last_fs = -1;
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("LayerSel",   64'(LayerSel),   64'(e.ls));
        check("ColData",    64'(ColData),    64'(e.col));
        check("FrameStart", 64'(FrameStart), 64'(e.fs));
        check("FrameReady", 64'(FrameReady), 64'(e.fr));
      end
      check("layersel_onehot0", 64'($countones(LayerSel) <= 1), 64'd1);
      if (LayerSel != '0) lit_cnt++;
      if (FrameStart) begin
        if (!en_broken && last_fs >= 0)
          check("framestart_period", 64'(cyc - last_fs), 64'(FRAME));
        last_fs   = cyc;
        en_broken = 1'b0;
      end
    end
  end

  initial begin
    Reset = 1'b1; Enable = 1'b0; FrameValid = 1'b0; Cells = '0; Brightness = '0;
    run(2);

    // Frame load and swap: layer 0 fully on, full brightness.
    in_rst = 1'b0; in_en = 1'b1; in_bright = 3;
    in_fv = 1'b1; in_cells = 64'h0000_0000_0000_FFFF;
    cycle();
    in_fv = 1'b0; in_cells = {$urandom, $urandom};
    run(3 * FRAME);

    // PWM duty per brightness level (7 lit cycles per level step per layer).
    lit_window(1, 28);
    lit_window(0, 0);
    lit_window(2, 56);
    lit_window(3, 112);

    // Backpressure: FrameValid held high with changing Cells.
    in_fv = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      in_cells = {$urandom, $urandom};
      cycle();
    end
    in_fv = 1'b0;
    run(2 * FRAME);

    // Enable drop mid-layer 2 with a frame pending.
    run_to(DWELL + 5);
    in_fv = 1'b1; in_cells = {$urandom, $urandom};
    cycle();
    in_fv = 1'b0;
    run_to(2 * DWELL + 10);
    in_en = 1'b0;
    run(6);
    in_en = 1'b1;
    run(2 * FRAME);

    // Asynchronous reset during layer 3; display must come back empty.
    run_to(3 * DWELL + 12);
    in_rst = 1'b1;
    run(2);
    in_rst = 1'b0;
    run(2 * FRAME);

    // Random traffic with Enable held high.
    for (int i = 0; i < 100 * FRAME; i++) begin
      in_fv    = ($urandom % 4) == 0;
      in_cells = {$urandom, $urandom};
      if ($urandom % 64 == 0) in_bright = int'($urandom % 4);
      cycle();
    end

    // Random traffic with Enable toggling and occasional reset.
    for (int i = 0; i < 40 * FRAME; i++) begin
      in_fv    = ($urandom % 3) == 0;
      in_cells = {$urandom, $urandom};
      if ($urandom % 64 == 0) in_bright = int'($urandom % 4);
      if ($urandom % 50 == 0) in_en = !in_en;
      in_rst = ($urandom % 1500) == 0;
      cycle();
    end
    in_rst = 1'b0; in_en = 1'b1;
    run(4);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
